dm_access_unit: RTL
===================

Name: dm_access_unit

Overview:
- Load/store access unit between the CPU memory stage and the data-memory SRAM wrapper.
- Accepts one load or store request per cycle over a valid/ready handshake.
- Drives the wrapper's active-low CEB/WEB/BWEB, word address and write data, and returns one response per accepted request.
- Handles the SRAM's 1-cycle read latency, byte-lane steering, load sign/zero extension, alignment/illegal-op errors, and backpressure via a hold register.

Parameters:
- ADDR_W, 14, SRAM word-address width; DM_A = req_addr[ADDR_W+1:2].
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I size/sign code.
- req_addr  in  32  byte address; bits above ADDR_W+1 ignored.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  aligned, extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3; no SRAM access was made.
- DM_CEB  out  1  chip enable, active low.
- DM_WEB  out  1  0 = write, 1 = read.
- DM_BWEB  out  32  bit write enable, active low.
- DM_A  out  ADDR_W  word address.
- DM_IN  out  32  write data.
- DM_OUT  in  32  SRAM read data; valid only in the cycle after a read access.

Behaviour:
- Codes:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Any other code is illegal.
- Misaligned:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
- Accepted request (fire = req_valid && req_ready):
  - Legal and aligned: DM_CEB=0 in the same cycle, combinational from req_*.
  - Error: DM_CEB=1, no SRAM access.
  - When not firing: DM_CEB=1, DM_WEB=1, DM_BWEB=all 1, DM_A=0, DM_IN=0.
- Store lanes: off = addr[1:0].
  - SB: DM_IN = wdata[7:0] replicated to all 4 bytes; DM_BWEB byte lane off = 0x00, other lanes 0xFF.
  - SH: halfword replicated to both halves; lane pair off[1] enabled.
  - SW: DM_BWEB = 0.
  - DM_WEB = 0.
- Load: DM_WEB=1, DM_BWEB=all 1.
- Registered per accepted request: we, funct3, addr[1:0], err.
- FSM states: IDLE, PEND, HOLD.
  - IDLE: resp_valid=0, req_ready=1. On fire, go to PEND.
  - PEND: resp_valid=1, response formed from DM_OUT. req_ready=resp_ready.
    - If resp_ready and fire: stay in PEND with new request, giving back-to-back throughput of 1/cycle.
    - If resp_ready and no fire: go to IDLE.
    - If !resp_ready: capture the formed response into the hold register and go to HOLD.
  - HOLD: resp_valid=1, data from hold register, req_ready=0. On resp_ready, go to IDLE.
- Load formatting: byte/half selected by stored off; LB/LH sign-extend, LBU/LHU zero-extend.
- Store and error responses: rdata=0. resp_err set only for error responses.
- Response order equals request order; at most one outstanding response.
- Reset, asynchronous, may occur mid-operation:
  - State=IDLE, hold register=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - DM_CEB=1, DM_WEB=1, DM_BWEB=all 1, DM_A=0, DM_IN=0.
  - Pending response is dropped. A store issued in the reset cycle may or may not reach SRAM; the bench must not rely on it.

Decomposition:
- Package dm_pkg:
  - funct3 localparams F3_B/H/W/BU/HU.
  - State enum {IDLE, PEND, HOLD}.
  - Response struct {rdata, err}.
- One sub-module dm_load_align (combinational): takes DM_OUT, funct3, off and produces the extended rdata. It is reused by the CPU writeback path if needed.

Test Plan:
- SW 0x1234_5678 @0x0000_0008, then LW @0x8 with resp_ready=1 -> store: DM_A=2, DM_BWEB=0, resp_rdata=0. Load: resp_valid the next cycle, rdata=0x1234_5678.
- SB 0xAB @0x0D, then LB @0x0D and LBU @0x0D -> DM_BWEB=0xFFFF_00FF, DM_IN=0xABAB_ABAB. LB rdata=0xFFFF_FFAB, LBU rdata=0x0000_00AB.
- SH 0x8001 @0x12, then LH and LHU @0x12 -> DM_BWEB=0x0000_FFFF. LH rdata=0xFFFF_8001, LHU rdata=0x0000_8001.
- LW @0x6, SH @0x3, funct3=011 -> DM_CEB stays 1, resp_err=1, rdata=0 for each, one response per request, in order.
- 8 back-to-back LWs with resp_ready=1 -> one response per cycle in issue order. Then hold resp_ready=0 for 3 cycles mid-burst -> resp_valid and rdata held stable, req_ready=0 during HOLD, no lost or duplicated response.
- Assert rst in a PEND cycle -> resp_valid=0 and DM_CEB=1 immediately (asynchronous). After release, the first LW returns correct data.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access unit: RV32I size codes,
// the response FSM state type, the response record and small decode helpers.
package dm_pkg;

  // RV32I funct3 size/sign codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Response-side FSM: nothing pending, SRAM result arriving, result parked
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  // One response as seen by the CPU memory stage
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  // Stores only know B/H/W; loads additionally have the unsigned variants
  function automatic logic f3Legal(input logic we, input logic [2:0] funct3);
    logic legal;
    legal = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !we;
      default:          legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Halfwords need an even address, words need a word-aligned address.
  // The low two funct3 bits carry the size for both signed and unsigned codes.
  function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// CPU-side request/response bus of the data-memory access unit.
// The CPU memory stage is the master; the access unit is the slave.
interface dm_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dm_load_align.sv
// Load data formatter: picks the addressed byte/halfword out of a 32-bit
// SRAM word and sign- or zero-extends it according to funct3.
// Purely combinational so the writeback path can reuse it as well.
module dm_load_align
  import dm_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection from the byte offset inside the word
  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0: w_byte = i_data[7:0];
      2'd1: w_byte = i_data[15:8];
      2'd2: w_byte = i_data[23:16];
      2'd3: w_byte = i_data[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_off[1] ? i_data[31:16] : i_data[15:0];
  end

  // Extension to 32 bits; unknown codes produce zero
  always_comb begin
    o_rdata = 32'h0000_0000;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_W:    o_rdata = i_data;
      F3_BU:   o_rdata = {24'h00_0000, w_byte};
      F3_HU:   o_rdata = {16'h0000, w_half};
      default: o_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Load/store access unit between the CPU memory stage and the data-memory
// SRAM wrapper. Requests go straight to the SRAM pins in the cycle they are
// accepted; the one-cycle-late read data is formatted in PEND, and a hold
// register parks the response when the consumer stalls.
module dm_access_unit
  import dm_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  dm_access_unit_if.slave   bus,
  output logic              DM_CEB,
  output logic              DM_WEB,
  output logic [DATA_W-1:0] DM_BWEB,
  output logic [ADDR_W-1:0] DM_A,
  output logic [DATA_W-1:0] DM_IN,
  input  logic [DATA_W-1:0] DM_OUT
);

  state_t      r_state;
  state_t      w_nextState;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_err;
  resp_t       r_hold;

  logic        w_ready;
  logic        w_fire;
  logic        w_err;
  logic [1:0]  w_off;
  logic [31:0] w_alignData;
  resp_t       w_formed;
  logic        w_unused;

  // Address bits above the SRAM window are deliberately ignored
  assign w_unused = &{1'b0, bus.req_addr[31:ADDR_W+2]};

  assign w_off = bus.req_addr[1:0];
  assign w_err = !f3Legal(bus.req_we, bus.req_funct3) || isMisaligned(bus.req_funct3, w_off);

  // Acceptance: always free when idle, only alongside a consumed response in
  // PEND, never while a parked response waits; nothing is taken during reset
  // so a half-reset request can never reach the SRAM pins
  always_comb begin
    w_ready = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE:    w_ready = 1'b1;
        PEND:    w_ready = bus.resp_ready;
        default: w_ready = 1'b0;
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign w_fire        = bus.req_valid && w_ready;

  // SRAM pin drive, combinational from the accepted request; errors and idle
  // cycles leave the macro deselected with all pins at their quiet values
  always_comb begin
    DM_CEB  = 1'b1;
    DM_WEB  = 1'b1;
    DM_BWEB = '1;
    DM_A    = '0;
    DM_IN   = '0;
    if (w_fire && !w_err) begin
      DM_CEB = 1'b0;
      DM_A   = bus.req_addr[ADDR_W+1:2];
      if (bus.req_we) begin
        DM_WEB = 1'b0;
        case (bus.req_funct3)
          F3_B: begin
            DM_IN   = {4{bus.req_wdata[7:0]}};
            DM_BWEB = ~(32'h0000_00FF << {w_off, 3'b000});
          end
          F3_H: begin
            DM_IN   = {2{bus.req_wdata[15:0]}};
            DM_BWEB = w_off[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
          end
          default: begin
            DM_IN   = bus.req_wdata;
            DM_BWEB = '0;
          end
        endcase
      end
    end
  end

  dm_load_align u_loadAlign (
    .i_data   (DM_OUT),
    .i_funct3 (r_funct3),
    .i_off    (r_off),
    .o_rdata  (w_alignData)
  );

  // Response built from the remembered request: stores and errors return zero
  always_comb begin
    w_formed.err   = r_err;
    w_formed.rdata = (r_we || r_err) ? 32'h0000_0000 : w_alignData;
  end

  // Response port: live SRAM-derived data in PEND, parked copy in HOLD
  always_comb begin
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'h0000_0000;
    bus.resp_err   = 1'b0;
    case (r_state)
      PEND: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = w_formed.rdata;
        bus.resp_err   = w_formed.err;
      end
      HOLD: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = r_hold.rdata;
        bus.resp_err   = r_hold.err;
      end
      default: ;
    endcase
  end

  // Next-state logic; PEND loops on itself for back-to-back traffic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_fire) w_nextState = PEND;
      PEND: begin
        if (!bus.resp_ready) w_nextState = HOLD;
        else if (w_fire)     w_nextState = PEND;
        else                 w_nextState = IDLE;
      end
      HOLD: if (bus.resp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State and hold register; DM_OUT is only valid in PEND, so a stalled
  // response must be captured on the way into HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == PEND && !bus.resp_ready) begin
        r_hold <= w_formed;
      end
    end
  end

  // Per-request context needed to format the response a cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_off    <= 2'b00;
      r_err    <= 1'b0;
    end else if (w_fire) begin
      r_we     <= bus.req_we;
      r_funct3 <= bus.req_funct3;
      r_off    <= w_off;
      r_err    <= w_err;
    end
  end

endmodule
